// File: rtl/exe_hazard_ctrl_pkg.sv
// defines: shared widths, forwarding select encoding and the shadow pipeline slot type.
package defines;
   localparam int N                = 32;
   localparam int FORWARD_SEL_LEN  = 2;
   localparam int REG_ADDR_LEN_DEF = 5;
   localparam logic [FORWARD_SEL_LEN-1:0] FWD_REG = 2'd0;
   localparam logic [FORWARD_SEL_LEN-1:0] FWD_MEM = 2'd1;
   localparam logic [FORWARD_SEL_LEN-1:0] FWD_WB  = 2'd2;
   typedef struct packed {
      logic                        valid;
      logic                        wb_en;
      logic [REG_ADDR_LEN_DEF-1:0] dest;
      logic                        mem_read;
   } slot_t;
endpackage

// File: rtl/exe_hazard_ctrl_fwd_select.sv
// fwd_select: single-source producer match against the EX and MEM shadows, giving a mux select and a hazard flag.
module fwd_select
   import defines::*;
(
   input  logic [REG_ADDR_LEN_DEF-1:0] i_src,
   input  logic                        i_en,
   input  logic                        i_fwd_en,
   input  slot_t                       i_ex,
   input  logic                        i_mem_hit,
   input  logic [REG_ADDR_LEN_DEF-1:0] i_mem_dest,
   output logic [FORWARD_SEL_LEN-1:0]  o_sel,
   output logic                        o_hazard
);
   logic w_nz, w_ex, w_mem;
   assign w_nz  = i_en & (i_src != '0);
   assign w_ex  = w_nz & i_ex.valid & i_ex.wb_en & (i_ex.dest == i_src);
   assign w_mem = w_nz & i_mem_hit & (i_mem_dest == i_src);
   assign o_sel = w_ex ? FWD_MEM : w_mem ? FWD_WB : FWD_REG;
   // a load in EX has no result yet; without forwarding any in-flight producer blocks
   assign o_hazard = (w_ex & i_ex.mem_read) | (!i_fwd_en & (w_ex | w_mem));
endmodule

// File: rtl/exe_hazard_ctrl.sv
// exe_hazard_ctrl: EX-stage forwarding selects, load-use stalls and multi-cycle hold sequencing.
module exe_hazard_ctrl
   import defines::*;
#(
   parameter int REG_ADDR_LEN = REG_ADDR_LEN_DEF,
   parameter int MUL_LAT      = 3
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       id_valid,
   input  logic [REG_ADDR_LEN-1:0]    id_src1,
   input  logic [REG_ADDR_LEN-1:0]    id_src2,
   input  logic                       id_use1,
   input  logic                       id_use2,
   input  logic                       id_is_store,
   input  logic                       id_wb_en,
   input  logic [REG_ADDR_LEN-1:0]    id_dest,
   input  logic                       id_mem_read,
   input  logic                       id_multi,
   input  logic                       flush,
   input  logic                       fwd_en,
   output logic [FORWARD_SEL_LEN-1:0] val1_sel,
   output logic [FORWARD_SEL_LEN-1:0] val2_sel,
   output logic [FORWARD_SEL_LEN-1:0] ST_val_sel,
   output logic                       stall_id,
   output logic                       bubble_ex,
   output logic                       exe_hold
);
   localparam int CNT_W = $clog2(MUL_LAT);
   typedef enum logic {IDLE, BUSY} state_t;
   state_t                      r_state;
   logic [CNT_W-1:0]            r_cnt;
   slot_t                       r_ex;
   // WB-slot producers are covered by register-file write-through, so only EX and MEM are shadowed
   logic                        r_mem_hit;
   logic [REG_ADDR_LEN-1:0]     r_mem_dest;
   logic [FORWARD_SEL_LEN-1:0]  r_sel1, r_sel2, r_sel_st;
   logic [FORWARD_SEL_LEN-1:0]  w_sel1, w_sel2, w_sel_st;
   logic                        w_h1, w_h2, w_h_st, w_busy, w_hazard, w_issue;
   slot_t                       w_id_slot;
   fwd_select u_val1 (.i_src(id_src1), .i_en(id_use1), .i_fwd_en(fwd_en), .i_ex(r_ex),
      .i_mem_hit(r_mem_hit), .i_mem_dest(r_mem_dest), .o_sel(w_sel1), .o_hazard(w_h1));
   fwd_select u_val2 (.i_src(id_src2), .i_en(id_use2), .i_fwd_en(fwd_en), .i_ex(r_ex),
      .i_mem_hit(r_mem_hit), .i_mem_dest(r_mem_dest), .o_sel(w_sel2), .o_hazard(w_h2));
   fwd_select u_st (.i_src(id_src2), .i_en(id_is_store), .i_fwd_en(fwd_en), .i_ex(r_ex),
      .i_mem_hit(r_mem_hit), .i_mem_dest(r_mem_dest), .o_sel(w_sel_st), .o_hazard(w_h_st));
   assign w_busy    = (r_state == BUSY);
   assign w_hazard  = id_valid & !flush & (w_h1 | w_h2 | w_h_st);
   assign w_issue   = id_valid & !w_hazard & !w_busy & !flush;
   assign w_id_slot = '{valid: 1'b1, wb_en: id_wb_en, dest: id_dest, mem_read: id_mem_read};
   assign exe_hold  = w_busy;
   assign stall_id  = w_busy | w_hazard;
   assign bubble_ex = rst_n & !w_busy & !w_issue;
   assign val1_sel   = r_sel1;
   assign val2_sel   = r_sel2;
   assign ST_val_sel = r_sel_st;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= IDLE;
         r_cnt      <= '0;
         r_ex       <= '0;
         r_mem_hit  <= 1'b0;
         r_mem_dest <= '0;
         r_sel1     <= FWD_REG;
         r_sel2     <= FWD_REG;
         r_sel_st   <= FWD_REG;
      end else begin
         r_ex       <= w_busy ? r_ex : w_issue ? w_id_slot : '0;
         r_mem_hit  <= !w_busy & r_ex.valid & r_ex.wb_en;
         r_mem_dest <= r_ex.dest;
         r_sel1     <= w_busy ? r_sel1 : w_issue ? w_sel1 : FWD_REG;
         r_sel2     <= w_busy ? r_sel2 : w_issue ? w_sel2 : FWD_REG;
         r_sel_st   <= w_busy ? r_sel_st : w_issue ? w_sel_st : FWD_REG;
         r_state    <= w_busy ? ((r_cnt == CNT_W'(1)) ? IDLE : BUSY) : ((w_issue & id_multi) ? BUSY : IDLE);
         r_cnt      <= w_busy ? r_cnt - 1'b1 : ((w_issue & id_multi) ? CNT_W'(MUL_LAT - 1) : '0);
      end
   end
endmodule

// File: tb/tb_exe_hazard_ctrl.sv
// tb_exe_hazard_ctrl: directed instruction sequence with a queue of expected EX-stage selects.
module tb_exe_hazard_ctrl;
   logic       clk = 1'b0;
   logic       rst_n, id_valid, id_use1, id_use2, id_is_store, id_wb_en, id_mem_read, id_multi, flush, fwd_en;
   logic [4:0] id_src1, id_src2, id_dest;
   logic [1:0] val1_sel, val2_sel, ST_val_sel;
   logic       stall_id, bubble_ex, exe_hold;
   int         errors = 0;
   int         checks = 0;
   logic [5:0] q[$];
   always #5 clk = ~clk;
   exe_hazard_ctrl dut (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
      .id_use1(id_use1), .id_use2(id_use2), .id_is_store(id_is_store), .id_wb_en(id_wb_en),
      .id_dest(id_dest), .id_mem_read(id_mem_read), .id_multi(id_multi), .flush(flush),
      .fwd_en(fwd_en), .val1_sel(val1_sel), .val2_sel(val2_sel), .ST_val_sel(ST_val_sel),
      .stall_id(stall_id), .bubble_ex(bubble_ex), .exe_hold(exe_hold)
   );
   task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   task automatic ins(input logic v, input logic [4:0] s1, input logic [4:0] s2, input logic [4:0] d,
                      input logic u1, input logic u2, input logic st, input logic wb, input logic mr,
                      input logic mul);
      id_valid = v; id_src1 = s1; id_src2 = s2; id_dest = d; id_use1 = u1; id_use2 = u2;
      id_is_store = st; id_wb_en = wb; id_mem_read = mr; id_multi = mul;
   endtask
   // called at a negedge with ID inputs already driven; returns at the next negedge
   task automatic step(input string tag, input logic es, input logic eb, input logic eh,
                       input logic [1:0] e1, input logic [1:0] e2, input logic [1:0] e3);
      logic [5:0] e;
      #2;
      chk({tag, "_ctl"}, {6'b0, stall_id, bubble_ex, exe_hold}, {6'b0, es, eb, eh});
      q.push_back({e1, e2, e3});
      @(posedge clk);
      #1;
      e = q.pop_front();
      chk({tag, "_sel"}, {3'b0, val1_sel, val2_sel, ST_val_sel}, {3'b0, e});
      @(negedge clk);
   endtask
   initial begin
      rst_n = 1'b0; flush = 1'b0; fwd_en = 1'b1;
      ins(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      repeat (2) @(negedge clk);
      chk("reset", {stall_id, bubble_ex, exe_hold, val1_sel, val2_sel, ST_val_sel}, 9'd0);
      rst_n = 1'b1;
      ins(1, 1, 2, 3, 1, 1, 0, 1, 0, 0); step("add_r3", 0, 0, 0, 0, 0, 0);
      ins(1, 3, 3, 4, 1, 1, 0, 1, 0, 0); step("sub_fwd", 0, 0, 0, 1, 1, 0);
      ins(1, 1, 2, 3, 1, 1, 0, 1, 0, 0); step("add_r3b", 0, 0, 0, 0, 0, 0);
      ins(1, 1, 0, 7, 1, 0, 0, 1, 0, 0); step("addi_r7", 0, 0, 0, 0, 0, 0);
      ins(1, 1, 3, 0, 1, 0, 1, 0, 0, 0); step("sw_r3", 0, 0, 0, 0, 0, 2);
      ins(1, 1, 0, 5, 1, 0, 0, 1, 1, 0); step("lw_r5", 0, 0, 0, 0, 0, 0);
      ins(1, 5, 1, 6, 1, 0, 0, 1, 0, 0); step("lu_stall", 1, 1, 0, 0, 0, 0);
      step("lu_issue", 0, 0, 0, 2, 0, 0);
      ins(1, 6, 2, 8, 1, 1, 0, 1, 0, 1); step("mul", 0, 0, 0, 1, 0, 0);
      ins(1, 8, 2, 9, 1, 1, 0, 1, 0, 0); step("hold1", 1, 0, 1, 1, 0, 0);
      flush = 1'b1; step("hold2_flush", 1, 0, 1, 1, 0, 0); flush = 1'b0;
      step("mul_dep", 0, 0, 0, 1, 0, 0);
      flush = 1'b1; step("flush", 0, 1, 0, 0, 0, 0); flush = 1'b0;
      ins(1, 1, 2, 0, 1, 1, 0, 1, 0, 0); step("add_r0", 0, 0, 0, 0, 0, 0);
      ins(1, 0, 0, 10, 1, 1, 1, 1, 0, 0); step("use_r0", 0, 0, 0, 0, 0, 0);
      fwd_en = 1'b0;
      ins(1, 1, 2, 3, 1, 1, 0, 1, 0, 0); step("nf_add", 0, 0, 0, 0, 0, 0);
      ins(1, 3, 3, 4, 1, 1, 0, 1, 0, 0); step("nf_stall1", 1, 1, 0, 0, 0, 0);
      step("nf_stall2", 1, 1, 0, 0, 0, 0);
      step("nf_issue", 0, 0, 0, 0, 0, 0);
      fwd_en = 1'b1;
      ins(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); step("idle", 0, 1, 0, 0, 0, 0);
      ins(1, 1, 2, 8, 1, 1, 0, 1, 0, 1); step("mul2", 0, 0, 0, 0, 0, 0);
      ins(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); step("hold_a", 1, 0, 1, 0, 0, 0);
      #2;
      chk("hold_cnt1", {8'b0, exe_hold}, 9'd1);
      rst_n = 1'b0;
      #1;
      chk("async_rst", {stall_id, bubble_ex, exe_hold, val1_sel, val2_sel, ST_val_sel}, 9'd0);
      @(negedge clk);
      rst_n = 1'b1;
      ins(1, 3, 3, 4, 1, 1, 0, 1, 0, 0); step("post_rst", 0, 0, 0, 0, 0, 0);
      ins(1, 4, 1, 5, 1, 1, 0, 1, 0, 0); step("post_fwd", 0, 0, 0, 1, 0, 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/exe_hazard_ctrl.md
Name: exe_hazard_ctrl

Overview:
- Pipeline controller for the execute stage: decides per instruction which source each execute-stage 3:1 operand/store-data mux selects (register value, MEM-stage ALU result, WB result).
- Detects load-use hazards, sequences multi-cycle execute operations (MUL) with a hold counter, and generates ID-stage stall and EX bubble controls.
- Sits beside the ID/EX pipeline register. Keeps its own shadow of in-flight destination registers, so it needs no taps from later stages.

Parameters:
- REG_ADDR_LEN, 5, register index width (architectural register 0 is hard-wired zero).
- MUL_LAT, 3, total execute cycles of a multi-cycle op; legal range 2..16.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- id_valid  in  1  valid instruction in ID requesting issue
- id_src1  in  REG_ADDR_LEN  source of val1
- id_src2  in  REG_ADDR_LEN  source of val2 and of store data
- id_use1  in  1  val1 comes from id_src1
- id_use2  in  1  val2 comes from id_src2 (0 means immediate)
- id_is_store  in  1  store data comes from id_src2
- id_wb_en  in  1  instruction writes id_dest
- id_dest  in  REG_ADDR_LEN  destination register
- id_mem_read  in  1  instruction is a load
- id_multi  in  1  instruction is a multi-cycle execute op
- flush  in  1  kill the instruction currently in ID (branch taken)
- fwd_en  in  1  forwarding enabled; 0 means resolve by stalling
- val1_sel  out  FORWARD_SEL_LEN  registered mux select, valid during EX
- val2_sel  out  FORWARD_SEL_LEN  registered mux select, valid during EX
- ST_val_sel  out  FORWARD_SEL_LEN  registered mux select, valid during EX
- stall_id  out  1  hold IF/ID registers
- bubble_ex  out  1  load a NOP into ID/EX this cycle
- exe_hold  out  1  hold ID/EX contents; multi-cycle unit busy; MEM receives a bubble

Behaviour:
- Select encoding: FWD_REG=0, FWD_MEM=1 (ALU_res_MEM), FWD_WB=2 (result_WB); 3 is illegal and never driven.
- Shadow slots EX, MEM and WB each hold {valid, wb_en, dest, mem_read}.
- Normal cycle: ID→EX, EX→MEM, MEM→WB.
- During exe_hold: EX is kept, MEM gets invalid, WB gets the old MEM.
- Producer match: slot valid, wb_en, dest==src, dest!=0. Register-file write-through covers WB-slot producers; no WB-slot forwarding.
- Select computation (combinational in ID, registered on issue):
  - match EX slot → FWD_MEM;
  - else match MEM slot → FWD_WB;
  - else FWD_REG.
  - The EX-slot match has priority over the MEM-slot match.
  - A select is forced to FWD_REG when its use bit (id_use1, id_use2, id_is_store) is 0.
- Hazard: the ID instruction needs a register (use1/use2/is_store) matched by the EX slot with mem_read=1 (load-use).
- With fwd_en=0, a hazard is also any needed register matched by the EX or MEM slot.
- Hazard and not held → stall_id=1, bubble_ex=1, EX slot loads invalid, select registers load 0.
- Load-use costs exactly 1 cycle. Next cycle the load sits in MEM and the select is FWD_WB.
- Issue = id_valid & !hazard & !exe_hold & !flush. On issue: EX slot ← ID fields, select registers ← computed selects.
- Not issuing and not held: EX slot ← invalid, selects ← 0, bubble_ex=1.
- FSM IDLE/BUSY with counter cnt:
  - IDLE→BUSY when a valid id_multi instruction issues; cnt←MUL_LAT-1.
  - In BUSY: exe_hold=1 and stall_id=1; cnt decrements each cycle; leave to IDLE in the cycle cnt==1 completes (EX occupied exactly MUL_LAT cycles).
  - Select outputs are honoured only in the first EX cycle; the multi-cycle unit latches its operands then. Selects hold their value through BUSY.
- Hold with simultaneous load-use: the hold wins. The hazard is re-evaluated against the updated slots on the release cycle.
- flush during BUSY: kills only the ID instruction; the held EX op completes.
- flush in IDLE: EX loads invalid and selects go to 0.
- Reset (async, rst_n=0): all slots invalid, selects 0, stall_id=0, bubble_ex=0, exe_hold=0, FSM IDLE, cnt=0. Reset mid-BUSY aborts immediately; outputs are cleared asynchronously.

Decomposition:
- Shared package `defines`:
  - already holds N and FORWARD_SEL_LEN (=2);
  - add the FWD_REG/FWD_MEM/FWD_WB localparams, the REG_ADDR_LEN default, and a packed struct slot_t {valid, wb_en, dest, mem_read}.
- One natural sub-module: `fwd_select`, a pure-combinational single-source select/match unit, instantiated three times (val1, val2, store).

Test Plan:
- ADD r3 then SUB r4,r3,r3 back-to-back, fwd_en=1 → SUB in EX with val1_sel=val2_sel=1; no stall.
- ADD r3; unrelated op; SW storing r3 → SW in EX with ST_val_sel=2, val2_sel=0 (immediate).
- LW r5 then ADD r6,r5,r1 → one cycle with stall_id=1, bubble_ex=1; ADD in EX with val1_sel=2, val2_sel=0.
- MUL (MUL_LAT=3) then ADD dependent on it → exe_hold high exactly 2 cycles after MUL enters EX; ADD issues next and gets val1_sel=1.
- Destination r0 producer followed by a consumer of r0 → all selects 0; fwd_en=0 with ADD r3 then use of r3 → 2 stall cycles, then sel=0.
- rst_n low mid-BUSY at cnt=1 → exe_hold, stall_id and all selects 0 immediately; after release the first instruction issues without stall.
